// File: rtl/pipe_pkg.sv
// Shared types for the vector ASIP control pipeline: the per-stage control
// bundle, the beat sequencer state encoding and the all-zero bubble.
package pipe_pkg;

    localparam int REG_AW = 4;

    typedef struct packed {
        logic [REG_AW-1:0] wa3;
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic              reg_write;
        logic              mem_to_reg;
    } pipe_ctrl_t;

    typedef enum logic {
        IDLE = 1'b0,
        VEC  = 1'b1
    } vec_state_e;

    localparam pipe_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/vec_beat_seq.sv
// Beat sequencer for the Execute stage: tracks how many beats a vector op has
// spent in E and requests a stall until its final beat.
//
// state | meaning
// IDLE  | E holds a scalar op or a bubble
// VEC   | E holds a multi-beat vector op
module vec_beat_seq
    import pipe_pkg::*;
#(
    parameter int NUM_BEATS = 4,
    parameter int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              vec_in,
    input  logic              flush,
    output logic [BEAT_W-1:0] beat,
    output logic              busy,
    output logic              last
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam bit                MULTI     = (NUM_BEATS > 1);

    vec_state_e        state;
    vec_state_e        state_next;
    logic [BEAT_W-1:0] beat_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    // last: whatever E holds leaves E on the coming edge (scalar, bubble or final beat)
    assign last = (state != VEC) || (beat == LAST_BEAT);
    assign busy = ~last;

    always_comb begin
        state_next = state;
        beat_next  = beat;
        if (busy) begin
            beat_next = beat + BEAT_W'(1);
        end else if (flush) begin
            state_next = IDLE;
            beat_next  = '0;
        end else if (load) begin
            state_next = (vec_in && MULTI) ? VEC : IDLE;
            beat_next  = '0;
        end
    end

endmodule

// File: rtl/vec_pipe_tracker.sv
// D->E, E->M and M->W control/address registers for the vector ASIP, with a
// vector op parked in E for NUM_BEATS cycles while F/D are stalled.
module vec_pipe_tracker
    import pipe_pkg::*;
#(
    parameter int NUM_BEATS = 4,
    parameter int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              VecOpD,
    input  logic              FlushE,
    output logic [REG_AW-1:0] RA1E,
    output logic [REG_AW-1:0] RA2E,
    output logic [REG_AW-1:0] WA3E,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic [REG_AW-1:0] WA3M,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic [REG_AW-1:0] WA3W,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [BEAT_W-1:0] VecBeatE,
    output logic              VecBusyE
);

    pipe_ctrl_t        d_ctrl;
    pipe_ctrl_t        e_q;
    logic              e_retire;
    logic [REG_AW-1:0] wa3_m, wa3_w;
    logic              reg_write_m, mem_to_reg_m, reg_write_w, mem_to_reg_w;

    assign d_ctrl = '{wa3: WA3D, ra1: RA1D, ra2: RA2D,
                      reg_write: RegWriteD, mem_to_reg: MemtoRegD};

    vec_beat_seq #(
        .NUM_BEATS (NUM_BEATS),
        .BEAT_W    (BEAT_W)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .load   (e_retire),
        .vec_in (VecOpD),
        .flush  (FlushE),
        .beat   (VecBeatE),
        .busy   (VecBusyE),
        .last   (e_retire)
    );

    // A FlushE seen while the vector op is still busy is dropped: E simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= BUBBLE;
        end else if (e_retire) begin
            e_q <= FlushE ? BUBBLE : d_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !e_retire) begin
            wa3_m        <= '0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
        end else begin
            wa3_m        <= e_q.wa3;
            reg_write_m  <= e_q.reg_write;
            mem_to_reg_m <= e_q.mem_to_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa3_w        <= '0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else begin
            wa3_w        <= wa3_m;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
        end
    end

    assign RA1E      = e_q.ra1;
    assign RA2E      = e_q.ra2;
    assign WA3E      = e_q.wa3;
    assign RegWriteE = e_q.reg_write;
    assign MemtoRegE = e_q.mem_to_reg;
    assign WA3M      = wa3_m;
    assign RegWriteM = reg_write_m;
    assign MemtoRegM = mem_to_reg_m;
    assign WA3W      = wa3_w;
    assign RegWriteW = reg_write_w;
    assign MemtoRegW = mem_to_reg_w;

endmodule

// File: tb/tb_vec_pipe_tracker.sv
// Directed and randomized checks of vec_pipe_tracker against an instruction-level
// model: an op sits in E for its beats, then shifts through M and W.
module tb_vec_pipe_tracker;

    localparam int NB = 4;
    localparam int AW = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] RA1D = '0, RA2D = '0, WA3D = '0;
    logic          RegWriteD = 1'b0, MemtoRegD = 1'b0, VecOpD = 1'b0, FlushE = 1'b0;
    logic [AW-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW, MemtoRegW;
    logic [BW-1:0] VecBeatE;
    logic          VecBusyE;

    int compared = 0;
    int mismatched = 0;

    // reference model: contents of each stage as an instruction record
    int m_e_ra1, m_e_ra2, m_e_wa3, m_e_rw, m_e_mr, m_e_vec, m_e_beat;
    int m_m_wa3, m_m_rw, m_m_mr;
    int m_w_wa3, m_w_rw, m_w_mr;

    vec_pipe_tracker #(.NUM_BEATS(NB)) dut (
        .clk(clk), .rst(rst),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .VecOpD(VecOpD), .FlushE(FlushE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WA3M(WA3M), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WA3W(WA3W), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .VecBeatE(VecBeatE), .VecBusyE(VecBusyE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_e_ra1 = 0; m_e_ra2 = 0; m_e_wa3 = 0; m_e_rw = 0; m_e_mr = 0;
        m_e_vec = 0; m_e_beat = 0;
        m_m_wa3 = 0; m_m_rw = 0; m_m_mr = 0;
        m_w_wa3 = 0; m_w_rw = 0; m_w_mr = 0;
    endtask

    function automatic int model_busy();
        return (m_e_vec != 0 && m_e_beat < NB - 1) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int busy;
        if (rst) begin
            model_clear();
        end else begin
            busy = model_busy();
            m_w_wa3 = m_m_wa3; m_w_rw = m_m_rw; m_w_mr = m_m_mr;
            if (busy != 0) begin
                m_m_wa3 = 0; m_m_rw = 0; m_m_mr = 0;
                m_e_beat++;
            end else begin
                m_m_wa3 = m_e_wa3; m_m_rw = m_e_rw; m_m_mr = m_e_mr;
                m_e_beat = 0;
                if (FlushE) begin
                    m_e_ra1 = 0; m_e_ra2 = 0; m_e_wa3 = 0; m_e_rw = 0; m_e_mr = 0;
                    m_e_vec = 0;
                end else begin
                    m_e_ra1 = RA1D; m_e_ra2 = RA2D; m_e_wa3 = WA3D;
                    m_e_rw = RegWriteD; m_e_mr = MemtoRegD;
                    m_e_vec = (VecOpD && NB > 1) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("RA1E", 32'(RA1E), 32'(m_e_ra1));
        chk("RA2E", 32'(RA2E), 32'(m_e_ra2));
        chk("WA3E", 32'(WA3E), 32'(m_e_wa3));
        chk("RegWriteE", 32'(RegWriteE), 32'(m_e_rw));
        chk("MemtoRegE", 32'(MemtoRegE), 32'(m_e_mr));
        chk("WA3M", 32'(WA3M), 32'(m_m_wa3));
        chk("RegWriteM", 32'(RegWriteM), 32'(m_m_rw));
        chk("MemtoRegM", 32'(MemtoRegM), 32'(m_m_mr));
        chk("WA3W", 32'(WA3W), 32'(m_w_wa3));
        chk("RegWriteW", 32'(RegWriteW), 32'(m_w_rw));
        chk("MemtoRegW", 32'(MemtoRegW), 32'(m_w_mr));
        chk("VecBeatE", 32'(VecBeatE), 32'(m_e_beat));
        chk("VecBusyE", 32'(VecBusyE), 32'(model_busy()));
    endtask

    // one clock: drive inputs, compare at the falling edge, advance model at the rising edge
    task automatic step(input int ra1, input int ra2, input int wa3, input bit rw,
                        input bit mr, input bit vec, input bit fl, input bit r);
        RA1D = AW'(ra1); RA2D = AW'(ra2); WA3D = AW'(wa3);
        RegWriteD = rw; MemtoRegD = mr; VecOpD = vec; FlushE = fl; rst = r;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_clear();
        // first edge only brings the DUT out of X; not compared
        RA1D = '1; RA2D = '1; WA3D = '1; RegWriteD = 1'b1; MemtoRegD = 1'b1; VecOpD = 1'b1;
        @(posedge clk);
        #1;

        // reset held with every D input high
        step(15, 15, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(15, 15, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_wa3e", 32'(WA3E), 32'd0);
        chk("rst_busy", 32'(VecBusyE), 32'd0);
        step(15, 15, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_release_wa3e", 32'(WA3E), 32'd15);
        chk("rst_release_busy", 32'(VecBusyE), 32'd1);
        for (int i = 0; i < NB + 2; i++) idle_step();

        // scalar op flows one stage per edge
        step(1, 2, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("scalar_wa3e", 32'(WA3E), 32'd5);
        idle_step();
        chk("scalar_wa3m", 32'(WA3M), 32'd5);
        chk("scalar_rwm", 32'(RegWriteM), 32'd1);
        idle_step();
        chk("scalar_wa3w", 32'(WA3W), 32'd5);
        chk("scalar_rww", 32'(RegWriteW), 32'd1);

        // vector op: three busy beats, M bubbled, then one retirement
        step(3, 4, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < NB - 1; b++) begin
            chk("vec_beat", 32'(VecBeatE), 32'(b));
            chk("vec_busy", 32'(VecBusyE), 32'd1);
            chk("vec_rwm_bubble", 32'(RegWriteM), 32'd0);
            step(9, 9, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("vec_last_beat", 32'(VecBeatE), 32'(NB - 1));
        chk("vec_last_busy", 32'(VecBusyE), 32'd0);
        idle_step();
        chk("vec_retire_wa3m", 32'(WA3M), 32'd7);
        chk("vec_retire_rwm", 32'(RegWriteM), 32'd1);

        // flush with a load in D: E becomes a bubble, previous E op still reaches M
        step(2, 2, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1, 1, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_wa3e", 32'(WA3E), 32'd0);
        chk("flush_mre", 32'(MemtoRegE), 32'd0);
        chk("flush_prev_wa3m", 32'(WA3M), 32'd6);

        // flush at beat 1 of a busy vector op is ignored
        step(0, 0, 11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_step();
        step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("busy_flush_wa3e", 32'(WA3E), 32'd11);
        chk("busy_flush_beat", 32'(VecBeatE), 32'd2);
        idle_step();
        chk("busy_flush_beat3", 32'(VecBeatE), 32'd3);
        idle_step();
        chk("busy_flush_wa3m", 32'(WA3M), 32'd11);

        // back-to-back vector ops, then reset at beat 2 of the second
        step(0, 0, 12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < NB - 1; b++) idle_step();
        step(0, 0, 13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_wa3e", 32'(WA3E), 32'd13);
        chk("b2b_beat", 32'(VecBeatE), 32'd0);
        idle_step();
        idle_step();
        step(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_busy", 32'(VecBusyE), 32'd0);
        chk("rst_mid_rwm", 32'(RegWriteM), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle_step();
            chk("rst_mid_no_wb", 32'(RegWriteW), 32'd0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(15), $urandom_range(15), $urandom_range(15),
                 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(2) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(49) == 0));
        end
        idle_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vec_pipe_tracker.md
Name: vec_pipe_tracker

Overview:
- Holds the control/address pipeline registers D->E, E->M and M->W for the vector ASIP.
- Drives the execute/memory/writeback fields that the hazard unit reads: RA1E, RA2E, WA3E, MemtoRegE, WA3M, RegWriteM, WA3W, RegWriteW.
- Consumes the hazard unit's FlushE.
- Adds a beat sequencer: a vector instruction occupies Execute for NUM_BEATS cycles and raises a stall request while it does.

Parameters:
- REG_AW, 4, register address width.
- NUM_BEATS, 4, execute cycles per vector op (VLEN/LANES), >=1.
- BEAT_W, $clog2(NUM_BEATS) (min 1), beat counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- RA1D  in  REG_AW  source A address in Decode.
- RA2D  in  REG_AW  source B address in Decode.
- WA3D  in  REG_AW  destination address in Decode.
- RegWriteD  in  1  Decode writes the register file.
- MemtoRegD  in  1  Decode instruction is a load.
- VecOpD  in  1  Decode instruction is a multi-beat vector op.
- FlushE  in  1  bubble request from the hazard unit.
- RA1E, RA2E, WA3E  out  REG_AW  Execute-stage addresses.
- RegWriteE, MemtoRegE  out  1  Execute-stage control.
- WA3M  out  REG_AW  Memory-stage destination address.
- RegWriteM, MemtoRegM  out  1  Memory-stage control.
- WA3W  out  REG_AW  Writeback-stage destination address.
- RegWriteW, MemtoRegW  out  1  Writeback-stage control.
- VecBeatE  out  BEAT_W  current beat index of the op in Execute.
- VecBusyE  out  1  stall request: F and D must hold.

Behaviour:
- Reset: rst synchronous, active-high, highest priority. All registered outputs go to 0 and the FSM goes to IDLE; VecBusyE=0. A reset mid vector op aborts it and no writeback is issued.
- FSM states: IDLE (E holds a scalar op or a bubble) and VEC (E holds a vector op).
- D/E register load, priority on each clock edge:
  - rst.
  - VEC && !last beat: hold the E fields and increment VecBeatE.
  - FlushE: E fields <= 0 (bubble), state IDLE.
  - Otherwise: load the D fields. Go to VEC if VecOpD && NUM_BEATS>1, else IDLE. VecBeatE <= 0.
- Last beat: VecBeatE == NUM_BEATS-1.
- VecBusyE is combinational: (state==VEC) && VecBeatE != NUM_BEATS-1.
  - Busy for NUM_BEATS-1 cycles after the op enters E.
  - FlushE arriving while VecBusyE=1 is ignored (D is stalled, nothing new enters).
- E/M register:
  - While VecBusyE=1, M receives a bubble (RegWriteM=0, MemtoRegM=0, WA3M=0).
  - Otherwise M <= {WA3E, RegWriteE, MemtoRegE}.
  - A vector op therefore reaches M exactly once, after its last beat.
- M/W register: W <= M every cycle. No stall and no flush beyond rst.
- Latency:
  - Scalar op: D->E 1 cycle, E->M 1, M->W 1.
  - Vector op: D->E 1, then NUM_BEATS cycles in E, then 1 to M and 1 to W.
- NUM_BEATS=1: VEC is never entered, VecBusyE stays 0, VecBeatE stays 0.
- Back-to-back vector ops: the second op loads into E on the edge that retires the first op's last beat. There is no idle gap.
- FlushE together with a vector op in D on a non-busy cycle: the flush wins, the vector op is not loaded, and the state is IDLE.
- All datapath widths are exact. VecBeatE never exceeds NUM_BEATS-1, and the counter is reset to 0 on every load or flush.

Decomposition:
- Package pipe_pkg holds:
  - localparam REG_AW.
  - typedef pipe_ctrl_t as a packed struct {wa3, ra1, ra2, reg_write, mem_to_reg}.
  - typedef vec_state_e as an enum {IDLE, VEC}.
  - A constant BUBBLE of type pipe_ctrl_t, all zero.
- One sub-module vec_beat_seq: the FSM plus the beat counter.
  - Inputs: load, vec_in, flush.
  - Outputs: beat, busy, last.
- The pipeline registers live in the top.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all D inputs 1 -> every output is 0 and VecBusyE=0. Release rst -> the D values appear in E after 1 edge.
- Scalar flow: WA3D=5, RegWriteD=1 at cycle 0 -> WA3E=5 at cycle 1, WA3M=5 and RegWriteM=1 at cycle 2, WA3W=5 and RegWriteW=1 at cycle 3.
- Vector op with NUM_BEATS=4: VecOpD=1, WA3D=7 -> VecBusyE=1 for 3 cycles with VecBeatE 0,1,2. RegWriteM=0 during those cycles. VecBeatE=3 with VecBusyE=0. Next edge gives WA3M=7, RegWriteM=1.
- FlushE=1 while D holds a load (MemtoRegD=1, WA3D=3) -> E is a bubble: RegWriteE=0, MemtoRegE=0, WA3E=0. The prior E op still moves into M.
- FlushE=1 while VecBusyE=1 at beat 1 -> flush ignored. WA3E is held and the beat sequence continues to 3.
- rst=1 at beat 2 of a vector op -> next cycle IDLE, VecBusyE=0, RegWriteM=0, and the op never reaches W.
